// File: rtl/led_pkg.sv
// Shared constants, colours and FSM state type for the LED frame sequencer.
// Optional build macro used by this block: LED_SERPENTINE_EN (see pixel_addr_map).
package led_pkg;

  localparam int unsigned COLS       = 12;
  localparam int unsigned ROWS       = 16;
  localparam int unsigned NUM_PIXELS = COLS * ROWS;

  localparam logic [23:0] ON_COLOR  = 24'h00FF00;
  localparam logic [23:0] OFF_COLOR = 24'h000000;

  // WS2812 latch needs >50 us of idle line; 10 us margin on top of the minimum.
  localparam int unsigned CLK_FREQ_MHZ    = 100;
  localparam int unsigned RESET_MIN_US    = 50;
  localparam int unsigned RESET_MARGIN_US = 10;
  localparam int unsigned GAP_CYCLES      = CLK_FREQ_MHZ * (RESET_MIN_US + RESET_MARGIN_US);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StDrain,
    StGap,
    StDone
  } seq_state_t;

endpackage

// File: rtl/pixel_addr_map.sv
// Maps the strip position (row, col) to a snapshot bit index.
// With LED_SERPENTINE_EN defined, odd rows are walked right-to-left.
module pixel_addr_map
  import led_pkg::*;
#(
  parameter int unsigned Cols = COLS,
  parameter int unsigned Rows = ROWS,
  parameter int unsigned RowW = 4,
  parameter int unsigned ColW = 4,
  parameter int unsigned IdxW = 8
) (
  input  logic [RowW-1:0] row_i,
  input  logic [ColW-1:0] col_i,
  output logic [IdxW-1:0] idx_o
);

  logic [ColW-1:0] col_eff;

  always_comb begin
    col_eff = col_i;
`ifdef LED_SERPENTINE_EN
    if (row_i[0]) col_eff = ColW'(Cols - 1) - col_i;
`endif
  end

  assign idx_o = IdxW'(32'(row_i) * Cols + 32'(col_eff));

endmodule

// File: rtl/led_frame_sequencer.sv
// Snapshots the pixel state on a frame request and streams one GRB word per LED to the
// WS2812 serializer, then holds the latch gap. Build option: LED_SERPENTINE_EN.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int unsigned Cols      = COLS,
  parameter int unsigned Rows      = ROWS,
  parameter logic [23:0] OnColor   = ON_COLOR,
  parameter logic [23:0] OffColor  = OFF_COLOR,
  parameter int unsigned GapCycles = GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_req_i,
  input  logic [Rows*Cols-1:0]   state_in_i,
  output logic [23:0]            px_data_o,
  output logic                   px_valid_o,
  input  logic                   px_ready_i,
  input  logic                   tx_idle_i,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int unsigned NumPix = Rows * Cols;
  localparam int unsigned RowW   = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned ColW   = (Cols > 1) ? $clog2(Cols) : 1;
  localparam int unsigned IdxW   = (NumPix > 1) ? $clog2(NumPix) : 1;
  localparam int unsigned GapW   = $clog2(GapCycles + 1);

  seq_state_t        state_q, state_d;
  logic [NumPix-1:0] snap_q, snap_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              pending_q, pending_d;

  logic [IdxW-1:0]   bit_idx;
  logic              accept;
  logic              last_col;
  logic              last_px;

  pixel_addr_map #(
    .Cols (Cols),
    .Rows (Rows),
    .RowW (RowW),
    .ColW (ColW),
    .IdxW (IdxW)
  ) u_addr_map (
    .row_i (row_q),
    .col_i (col_q),
    .idx_o (bit_idx)
  );

  assign px_valid_o   = (state_q == StSend);
  assign accept       = px_valid_o && px_ready_i;
  assign last_col     = (col_q == ColW'(Cols - 1));
  assign last_px      = last_col && (row_q == RowW'(Rows - 1));
  assign px_data_o    = px_valid_o ? (snap_q[bit_idx] ? OnColor : OffColor) : 24'h000000;
  assign frame_done_o = (state_q == StDone);
  // An IDLE cycle that is about to serve a pending request counts as busy, so busy only
  // dips for the DONE cycle between back-to-back frames.
  assign busy_o       = !((state_q == StDone) || ((state_q == StIdle) && !pending_q));

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    row_d     = row_q;
    col_d     = col_q;
    gap_d     = gap_q;
    pending_d = pending_q;

    if (frame_req_i && (state_q != StIdle)) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (frame_req_i || pending_q) begin
          state_d   = StLoad;
          pending_d = 1'b0;
        end
      end
      StLoad: begin
        snap_d  = state_in_i;
        row_d   = '0;
        col_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (accept) begin
          if (last_px) begin
            state_d = StDrain;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (tx_idle_i) begin
          state_d = StGap;
          gap_d   = '0;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GapCycles - 1)) state_d = StDone;
        else                               gap_d   = gap_q + 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      gap_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      row_q     <= row_d;
      col_q     <= col_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench for led_frame_sequencer; expected words come from a strip-order model.
module tb_led_frame_sequencer;
  import led_pkg::*;

  localparam int unsigned NPix = NUM_PIXELS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_req_i = 1'b0;
  logic [NPix-1:0] state_in_i = '0;
  logic [23:0]     px_data_o;
  logic            px_valid_o;
  logic            px_ready_i = 1'b0;
  logic            tx_idle_i = 1'b0;
  logic            busy_o;
  logic            frame_done_o;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  led_frame_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_req_i  (frame_req_i),
    .state_in_i   (state_in_i),
    .px_data_o    (px_data_o),
    .px_valid_o   (px_valid_o),
    .px_ready_i   (px_ready_i),
    .tx_idle_i    (tx_idle_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Strip-order reference: LED n sits at row n/COLS; column reversed on odd rows if serpentine.
  function automatic logic [23:0] exp_word(input logic [NPix-1:0] snap, input int n);
    int r;
    int c;
    r = n / COLS;
    c = n % COLS;
`ifdef LED_SERPENTINE_EN
    if (r % 2 == 1) c = COLS - 1 - c;
`endif
    return snap[r * COLS + c] ? ON_COLOR : OFF_COLOR;
  endfunction

  function automatic logic [NPix-1:0] rand_state();
    logic [NPix-1:0] v;
    for (int i = 0; i < NPix; i += 32) v[i +: 32] = $urandom();
    return v;
  endfunction

  task automatic start_frame();
    frame_req_i = 1'b1;
    @(negedge clk);
    frame_req_i = 1'b0;
    check("busy_after_req", busy_o, 1);
  endtask

  // mode: 0 ready always, 1 ready one cycle in three, 2 random ready.
  task automatic stream_frame(input logic [NPix-1:0] snap, input int mode, input bit toggle,
                              input int req_a, input int req_b, input bit req_gap,
                              input int abort_at, input bit exp_pending);
    int          acc = 0;
    int          cyc = 0;
    int          wait_n = 0;
    int          cnt;
    int          k;
    bit          stalled = 0;
    bit          ra_done = 0;
    bit          rb_done = 0;
    logic [23:0] held = '0;
    logic        rdy;

    while (px_valid_o !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("first_valid", px_valid_o, 1);
    if (px_valid_o !== 1'b1) return;

    while (acc < NPix && cyc < NPix * 20) begin
      if (toggle) state_in_i = ~state_in_i;
      if (acc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", px_valid_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done", frame_done_o, 0);
        @(negedge clk);
        rst_n       = 1'b1;
        px_ready_i  = 1'b0;
        frame_req_i = 1'b0;
        return;
      end
      frame_req_i = 1'b0;
      if (!ra_done && acc == req_a) begin frame_req_i = 1'b1; ra_done = 1; end
      else if (!rb_done && acc == req_b) begin frame_req_i = 1'b1; rb_done = 1; end
      tx_idle_i = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      check("valid_in_send", px_valid_o, 1);
      if (stalled) check("stall_stable", px_data_o, held);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      px_ready_i = rdy;
      if (rdy) begin
        check($sformatf("word%0d", acc), px_data_o, exp_word(snap, acc));
        acc++;
        stalled = 0;
      end else begin
        stalled = 1;
        held    = px_data_o;
      end
      cyc++;
      @(negedge clk);
    end

    px_ready_i  = 1'b0;
    frame_req_i = 1'b0;
    tx_idle_i   = 1'b0;
    check("accept_count", acc, NPix);
    if (acc != NPix) return;
    check("valid_drop", px_valid_o, 0);
    check("busy_drain", busy_o, 1);

    k = $urandom_range(0, 5);
    for (int i = 0; i < k; i++) @(negedge clk);
    check("drain_wait_done", frame_done_o, 0);
    tx_idle_i = 1'b1;
    @(negedge clk);

    cnt = 1;
    while (frame_done_o !== 1'b1 && cnt < GAP_CYCLES + 50) begin
      frame_req_i = (req_gap && cnt == 100);
      if (cnt == 200) check("gap_valid", px_valid_o, 0);
      @(negedge clk);
      cnt++;
    end
    frame_req_i = 1'b0;
    check("gap_len", cnt, GAP_CYCLES + 1);
    check("done_busy", busy_o, 0);
    @(negedge clk);
    check("done_pulse", frame_done_o, 0);
    check("busy_after_done", busy_o, exp_pending);
  endtask

  initial begin
    logic [NPix-1:0] st;

    repeat (2) @(negedge clk);
    check("rst_valid", px_valid_o, 0);
    check("rst_data", px_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", frame_done_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single lit pixel at bit 0.
    st = '0;
    st[0] = 1'b1;
    state_in_i = st;
    start_frame();
    stream_frame(st, 0, 0, -1, -1, 0, -1, 0);

    // Backpressure, ready one cycle in three.
    st = rand_state();
    state_in_i = st;
    start_frame();
    stream_frame(st, 1, 0, -1, -1, 0, -1, 0);

    // Input toggling every cycle after LOAD must not tear the frame.
    st = rand_state();
    state_in_i = st;
    start_frame();
    stream_frame(st, 2, 1, -1, -1, 0, -1, 0);

    // Requests during SEND and GAP collapse into exactly one follow-on frame.
    st = rand_state();
    state_in_i = st;
    start_frame();
    stream_frame(st, 2, 0, 30, 90, 1, -1, 1);
    stream_frame(st, 0, 0, -1, -1, 0, -1, 0);
    repeat (20) @(negedge clk);
    check("no_third_busy", busy_o, 0);
    check("no_third_valid", px_valid_o, 0);

    // Reset mid-frame, then a fresh frame restarts at LED 0.
    st = rand_state();
    state_in_i = st;
    start_frame();
    stream_frame(st, 0, 0, -1, -1, 0, 100, 0);
    check("post_abort_busy", busy_o, 0);
    st = rand_state();
    state_in_i = st;
    start_frame();
    stream_frame(st, 2, 0, -1, -1, 0, -1, 0);

    // Row 1, col 0: LED 12 linear, LED 23 serpentine.
    st = '0;
    st[12] = 1'b1;
    state_in_i = st;
    start_frame();
    stream_frame(st, 0, 0, -1, -1, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Schedules refresh of the 12-column x 16-row LED matrix from the engine's pixel state.
- On each frame request: snapshots the state vector, then streams one 24-bit GRB word per LED, in strip order, to the WS2812 bit serializer over a valid/ready handshake.
- After the last word it enforces the >50 us low reset/latch gap and signals frame completion.
- Sits between the engine's state output and the display serializer.

Parameters:
- COLS, 12, pixels per row
- ROWS, 16, rows per frame
- ON_COLOR, 24'h00FF00, GRB word for a lit pixel (state bit 1)
- OFF_COLOR, 24'h000000, GRB word for a dark pixel (state bit 0)
- GAP_CYCLES, 6000, clk cycles the line is held idle after the frame (60 us at 100 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_req  in  1  one-cycle pulse requesting a refresh (from game clock)
- state_in  in  ROWS*COLS  pixel state; bit r*COLS+c = row r (0 = top), column c
- px_data  out  24  GRB word for the current LED
- px_valid  out  1  px_data valid to serializer
- px_ready  in  1  serializer accepts px_data this cycle
- tx_idle  in  1  serializer has finished shifting all accepted bits
- busy  out  1  high from frame start until frame_done
- frame_done  out  1  one-cycle pulse at end of reset gap

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: px_data=0, px_valid=0, busy=0, frame_done=0; FSM=IDLE; snapshot, counters and pending flag cleared.
- Reset asserted mid-frame aborts immediately. px_valid drops asynchronously; no partial-frame recovery.
- FSM states: IDLE, LOAD, SEND, DRAIN, GAP, DONE.
- IDLE:
  - frame_req or pending -> LOAD.
  - busy rises the cycle after the frame_req is sampled.
- LOAD:
  - One cycle.
  - Copies state_in into the internal snapshot; pix_idx=0.
  - Later state_in changes do not affect the frame in flight (no tearing).
  - -> SEND.
- SEND:
  - px_valid=1; px_data = snapshot bit for pix_idx mapped to ON_COLOR/OFF_COLOR.
  - px_data and px_valid stay stable until px_ready.
  - On valid&&ready: pix_idx++. Next word is presented the following cycle, so back-to-back acceptance is allowed.
  - Accepting pix_idx = ROWS*COLS-1: px_valid drops the next cycle, -> DRAIN.
- DRAIN:
  - Waits for tx_idle=1.
  - tx_idle is ignored until the cycle after the last accept.
  - -> GAP with gap counter = 0.
- GAP:
  - Counts GAP_CYCLES cycles; px_valid stays 0.
  - -> DONE.
- DONE:
  - frame_done=1 for one cycle; busy=0 the same cycle.
  - -> IDLE.
- Pixel mapping, linear: LED n = pix_idx, row = n / COLS, col = n % COLS.
  - Use row/column counters, not divide: col wraps at COLS-1 and increments row.
- Frame request while busy:
  - Sets a one-deep pending flag; extra requests are dropped.
  - Pending is served from IDLE on the cycle after DONE.
  - frame_req in the DONE cycle also sets pending.
- Widths: pix_idx $clog2(ROWS*COLS) bits (8 at default); gap counter $clog2(GAP_CYCLES+1) bits. No wrap beyond terminal counts.

Optional Feature:
- Macro LED_SERPENTINE_EN.
- Defined: strip is wired boustrophedon. On odd rows, LED order within the row is reversed: bit index = r*COLS + (COLS-1-c).
- Undefined: linear mapping as above.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package led_pkg:
  - COLS, ROWS, NUM_PIXELS, GRB color constants.
  - FSM state enum seq_state_t.
  - GAP_CYCLES default derived from clock frequency and 50 us minimum.
- Sub-module pixel_addr_map: combinational (row, col) -> snapshot bit index, holding the serpentine option.
- FSM, counters and snapshot stay in the top.

Test Plan:
- Reset then single frame_req, px_ready tied 1, tx_idle 1 after last accept, state_in bit0=1 only:
  - 192 accepts.
  - First word 24'h00FF00, remaining 191 words 24'h000000.
  - frame_done exactly 6000 cycles after DRAIN exit.
- Backpressure: px_ready toggles 1-in-3 cycles:
  - px_data stable while px_valid && !px_ready.
  - Still exactly 192 accepts, no duplicates or skips.
- Snapshot: toggle all state_in bits every cycle after LOAD:
  - Streamed words all match the LOAD-cycle value.
- Two frame_req pulses during SEND plus one in GAP:
  - Exactly one extra frame follows.
  - busy low for the single DONE cycle between frames.
- rst_n low at pix_idx=100:
  - px_valid=0 and busy=0 asynchronously.
  - Next frame_req restarts at pix_idx 0.
- LED_SERPENTINE_EN with state_in bit 12 (row1,col0)=1:
  - Lit word appears as LED 23, not LED 12.
